// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared constants, FSM encoding and digit-count helper
package ps2_mouse_pkg;

  localparam int DELTA_W = 9;
  localparam int MAG_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } dd_state_e;

  // Smallest digit count whose decimal range covers 2^acc_w - 1.
  function automatic int min_digits(input int acc_w);
    longint unsigned lim;
    longint unsigned p;
    int d;
    lim = (64'd1 << acc_w) - 64'd1;
    p   = 64'd10;
    d   = 1;
    for (int i = 0; i < 20; i++) begin
      if (p <= lim) begin
        p = p * 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_double_dabble_seq.sv
// rtl/bcd_double_dabble_seq.sv - iterative binary-to-BCD converter, one bit per cycle
module bcd_double_dabble_seq
  import ps2_mouse_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  loading,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(BIN_W);

  dd_state_e             state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Digits >= 5 get +3 before the shift so the doubling carries into the next digit.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    end
  end

  always_comb begin
    bin_d  = bin_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    done_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bin_d = bin_in;
        scr_d = '0;
        cnt_d = '0;
      end
      ST_SHIFT: begin
        scr_d = {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: begin
        bcd_d  = scr_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    loading = (state_q == ST_LOAD);
    done    = done_q;
    bcd_out = bcd_q;
  end

endmodule

// File: rtl/path_accumulator_bcd.sv
// rtl/path_accumulator_bcd.sv - Manhattan travel accumulator feeding a sequential BCD converter
module path_accumulator_bcd
  import ps2_mouse_pkg::*;
#(
  parameter int ACC_W    = 16,
  parameter int DIGITS   = 5,
  parameter int SATURATE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reset_button,
  input  logic                 done_tick,
  input  logic [DELTA_W-1:0]   x_axis,
  input  logic [DELTA_W-1:0]   y_axis,
  output logic [ACC_W-1:0]     acc_value,
  output logic                 overflow,
  output logic [4*DIGITS-1:0]  bcd,
  output logic                 bcd_valid,
  output logic                 busy
);

  if (DIGITS < min_digits(ACC_W)) begin : g_digits_too_small
    $error("DIGITS too small for ACC_W");
  end

  function automatic logic [MAG_W-1:0] abs_delta(input logic [DELTA_W-1:0] v);
    logic [MAG_W-1:0] e;
    e = {v[DELTA_W-1], v};
    return v[DELTA_W-1] ? (~e + MAG_W'(1)) : e;
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             dirty_q, dirty_d;
  logic [MAG_W-1:0] delta;
  logic [ACC_W:0]   sum;
  logic             loading;

  assign delta = abs_delta(x_axis) + abs_delta(y_axis);
  assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(delta);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      dirty_q <= dirty_d;
    end
  end

  // A set of dirty in the snapshot cycle must win so the newer value gets converted.
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    dirty_d = dirty_q;
    if (loading) dirty_d = 1'b0;
    if (reset_button) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      dirty_d = 1'b1;
    end else if (done_tick) begin
      dirty_d = 1'b1;
      if (sum[ACC_W]) begin
        ovf_d = 1'b1;
        acc_d = (SATURATE != 0) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  bcd_double_dabble_seq #(
    .BIN_W  (ACC_W),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk     (clk),
    .rst     (rst),
    .start   (dirty_q),
    .bin_in  (acc_q),
    .busy    (busy),
    .loading (loading),
    .done    (bcd_valid),
    .bcd_out (bcd)
  );

  assign acc_value = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_path_accumulator_bcd.sv
// tb/tb_path_accumulator_bcd.sv - scoreboard bench for saturating and wrapping accumulators
module tb_path_accumulator_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reset_button = 1'b0;
  logic        done_tick = 1'b0;
  logic [8:0]  x_axis = '0;
  logic [8:0]  y_axis = '0;

  logic [15:0] acc_s, acc_w;
  logic        ovf_s, ovf_w;
  logic [19:0] bcd_s, bcd_w;
  logic        val_s, val_w;
  logic        busy_s, busy_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [19:0] bcd;
    int          cyc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];

  int m_acc_s = 0, m_acc_w = 0;
  bit m_ovf_s = 0, m_ovf_w = 0;

  path_accumulator_bcd #(.ACC_W(16), .DIGITS(5), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .reset_button(reset_button), .done_tick(done_tick),
    .x_axis(x_axis), .y_axis(y_axis), .acc_value(acc_s), .overflow(ovf_s),
    .bcd(bcd_s), .bcd_valid(val_s), .busy(busy_s)
  );

  path_accumulator_bcd #(.ACC_W(16), .DIGITS(5), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .reset_button(reset_button), .done_tick(done_tick),
    .x_axis(x_axis), .y_axis(y_axis), .acc_value(acc_w), .overflow(ovf_w),
    .bcd(bcd_w), .bcd_valid(val_w), .busy(busy_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int mag9(input logic [8:0] v);
    int s;
    s = (v[8]) ? int'(v) - 512 : int'(v);
    return (s < 0) ? -s : s;
  endfunction

  task automatic push_exp(input int at);
    exp_t e;
    e.bcd = to_bcd(m_acc_s); e.cyc = at; q_s.push_back(e);
    e.bcd = to_bcd(m_acc_w); e.cyc = at; q_w.push_back(e);
  endtask

  task automatic drive(input logic [8:0] x, input logic [8:0] y, input logic tick,
                       input logic clr, output int t);
    int s;
    @(posedge clk); #1;
    x_axis = x; y_axis = y; done_tick = tick; reset_button = clr; t = cyc;
    if (clr) begin
      m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0;
    end else if (tick) begin
      s = m_acc_s + mag9(x) + mag9(y);
      if (s > 65535) begin m_ovf_s = 1; s = 65535; end
      m_acc_s = s;
      s = m_acc_w + mag9(x) + mag9(y);
      if (s > 65535) begin m_ovf_w = 1; s = s - 65536; end
      m_acc_w = s;
    end
    @(posedge clk); #1;
    done_tick = 1'b0; reset_button = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q_s.size() == 0 && q_w.size() == 0 && !busy_s && !busy_w) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 1, 0);
  endtask

  // Scoreboard side: every bcd_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (val_s) begin
        if (q_s.size() == 0) check("spurious_valid_s", 1, 0);
        else begin
          exp_t e;
          e = q_s.pop_front();
          check("bcd_s", bcd_s, e.bcd);
          check("latency_s", cyc, e.cyc);
        end
      end
      if (val_w) begin
        if (q_w.size() == 0) check("spurious_valid_w", 1, 0);
        else begin
          exp_t e;
          e = q_w.pop_front();
          check("bcd_w", bcd_w, e.bcd);
          check("latency_w", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int t, t2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_acc", acc_s, 0);
    check("rst_ovf", ovf_s, 0);
    check("rst_bcd", bcd_s, 0);
    check("rst_valid", val_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_acc_w", acc_w, 0);

    // single packet: 5 + |-3| = 8
    drive(9'h005, 9'h1FD, 1'b1, 1'b0, t);
    check("single_acc", acc_s, 8);
    push_exp(t + 20);
    wait_idle();

    // extreme deltas
    for (int i = 1; i <= 3; i++) begin
      drive(9'h100, 9'h100, 1'b1, 1'b0, t);
      check("extreme_acc", acc_s, 8 + 512 * i);
      push_exp(t + 20);
      wait_idle();
    end
    drive(9'h000, 9'h000, 1'b0, 1'b1, t);
    push_exp(t + 20);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      drive(9'h100, 9'h100, 1'b1, 1'b0, t);
      push_exp(t + 20);
      wait_idle();
    end
    check("extreme_1536", acc_s, 1536);
    check("extreme_bcd", bcd_s, 20'h01536);

    // saturation and wrap over 128 maximal packets
    drive(9'h000, 9'h000, 1'b0, 1'b1, t);
    push_exp(t + 20);
    wait_idle();
    for (int i = 1; i <= 128; i++) begin
      drive(9'h100, 9'h100, 1'b1, 1'b0, t);
      push_exp(t + 20);
      if (i == 127) check("pre_ovf", ovf_s, 0);
      wait_idle();
    end
    check("sat_acc", acc_s, 65535);
    check("sat_ovf", ovf_s, 1);
    check("sat_bcd", bcd_s, 20'h65535);
    check("wrap_acc", acc_w, 0);
    check("wrap_ovf", ovf_w, 1);
    drive(9'h001, 9'h000, 1'b1, 1'b0, t);
    check("sat_hold", acc_s, 65535);
    check("wrap_one", acc_w, 1);
    push_exp(t + 20);
    wait_idle();

    // tick arriving mid-conversion
    drive(9'h000, 9'h000, 1'b0, 1'b1, t);
    push_exp(t + 20);
    wait_idle();
    drive(9'd10, 9'h000, 1'b1, 1'b0, t);
    push_exp(t + 20);
    repeat (3) @(posedge clk);
    drive(9'd20, 9'h000, 1'b1, 1'b0, t2);
    check("busy_tick_time", t2, t + 5);
    push_exp(t + 39);
    wait_idle();
    check("busy_acc", acc_s, 30);

    // rst mid-conversion: no bcd_valid, all outputs cleared
    drive(9'd3, 9'h000, 1'b1, 1'b0, t);
    while (cyc < t + 10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0;
    @(negedge clk);
    check("midrst_acc", acc_s, 0);
    check("midrst_ovf", ovf_s, 0);
    check("midrst_bcd", bcd_s, 0);
    check("midrst_busy", busy_s, 0);
    repeat (40) @(negedge clk);
    check("midrst_still_idle", busy_s, 0);

    // clear wins over a simultaneous tick
    drive(9'd7, 9'h000, 1'b1, 1'b0, t);
    push_exp(t + 20);
    wait_idle();
    drive(9'd50, 9'd50, 1'b1, 1'b1, t);
    check("clr_acc", acc_s, 0);
    check("clr_acc_w", acc_w, 0);
    push_exp(t + 20);
    wait_idle();
    check("clr_bcd", bcd_s, 0);

    check("q_s_empty", q_s.size(), 0);
    check("q_w_empty", q_w.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/path_accumulator_bcd.md
# path_accumulator_bcd

Parametrised mouse-travel accumulator with a sequential binary-to-BCD converter. It sits between the PS/2 packet decoder and the 7-segment display driver. On every completed movement packet it adds the Manhattan length |dx|+|dy| to a saturating or wrapping accumulator. An iterative double-dabble engine converts the accumulator into a glitch-free, registered BCD display word with a valid strobe.

## Interface
Parameters:
- ACC_W, 16: accumulator width in bits; range 10..32.
- DIGITS, 5: number of BCD digits. Must satisfy 10^DIGITS > 2^ACC_W−1; otherwise elaboration fails.
- SATURATE, 1: 1 clamps the accumulator at 2^ACC_W−1; 0 wraps modulo 2^ACC_W.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reset_button  in  1  synchronous clear of the accumulator; one-cycle or level.
- done_tick  in  1  one-cycle strobe: x_axis and y_axis hold a valid packet.
- x_axis  in  9  two's-complement X delta.
- y_axis  in  9  two's-complement Y delta.
- acc_value  out  ACC_W  current accumulator value.
- overflow  out  1  sticky; set when an addition exceeds 2^ACC_W−1.
- bcd  out  4*DIGITS  last completed conversion, most significant digit first.
- bcd_valid  out  1  one-cycle pulse when bcd updates.
- busy  out  1  high while a conversion is in progress (LOAD, SHIFT or DONE).

## Operation
- Delta magnitude:
  - |x|+|y|, computed as a 10-bit unsigned value.
  - |−256| = 256, so the maximum per packet is 512.
- Accumulate on done_tick:
  - sum = acc + delta, computed at ACC_W+1 bits.
  - If bit ACC_W is set: overflow <= 1, and acc <= 2^ACC_W−1 (SATURATE=1) or sum[ACC_W-1:0] (SATURATE=0).
- reset_button: acc <= 0 and overflow <= 0.
  - It takes priority over a simultaneous done_tick, and that packet is discarded.
- dirty flag:
  - Set by any accepted tick or by reset_button.
  - Cleared when the FSM snapshots acc in LOAD.
  - If a set and a clear land in the same cycle, the set wins.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE→LOAD when dirty=1.
  - LOAD: snapshot acc into a shift register, clear the BCD scratch, cnt <= 0.
  - SHIFT: each cycle, add 3 to every scratch digit ≥5, then shift {scratch, bin} left by 1. Leave SHIFT when cnt = ACC_W−1.
  - DONE: bcd <= scratch, bcd_valid <= 1, →IDLE.
- Changes during a conversion:
  - Ticks arriving while busy update acc and set dirty.
  - The running conversion completes with its snapshot, then IDLE immediately re-enters LOAD.
  - A conversion is never aborted by a tick or by reset_button.
- bcd holds its value between conversions, so the display never shows partial digits.

## Timing
- Reset values: acc_value=0, overflow=0, bcd=0, bcd_valid=0, busy=0. FSM in IDLE, dirty=0.
- acc_value and overflow update on the edge that ends the done_tick cycle T, and are visible in T+1.
- Conversion latency:
  - IDLE sees dirty in T+1.
  - LOAD runs in T+2; SHIFT runs in T+3..T+ACC_W+2; DONE runs in T+ACC_W+3.
  - bcd and bcd_valid are visible in T+ACC_W+4, i.e. T+20 for ACC_W=16.
- busy is high from LOAD through DONE: ACC_W+2 cycles.
- Back-to-back conversions: minimum period is ACC_W+3 cycles from bcd_valid to bcd_valid.
- rst mid-conversion: next cycle all state is at reset values, no bcd_valid is issued, and dirty is lost.
- done_tick is honoured every cycle, including consecutive cycles.

## Structure
- Shared package/header ps2_mouse_pkg holds:
  - the FSM state encodings (2 bits);
  - DELTA_W=9;
  - the magnitude-width constant 10;
  - a function computing the minimum DIGITS for a given ACC_W.
- Sub-module bcd_double_dabble_seq (params BIN_W, DIGITS) contains:
  - the FSM and shift registers;
  - start/bin_in inputs and busy/done/bcd_out outputs.
- The top level keeps the accumulator, overflow, dirty logic and magnitude computation.

## Test plan
- Single packet: after rst, done_tick with x=9'h005, y=9'h1FD → acc_value=8 in T+1; bcd=20'h00008 with a bcd_valid pulse in T+20.
- Extreme deltas: x=9'h100, y=9'h100 → delta 512; 3 ticks → acc=1536, bcd=20'h01536.
- Saturation (SATURATE=1): 128 ticks of x=y=9'h100 → acc=65535 at the 128th tick, overflow=1, final bcd=20'h65535. A further tick leaves acc unchanged.
- Wrap (SATURATE=0): same stimulus → acc=0 after the 128th tick, overflow=1. A tick with x=1, y=0 → acc=1.
- Tick during busy: tick x=10 at T, tick x=20 at T+5:
  - first bcd_valid at T+20 with 20'h00010;
  - second bcd_valid at T+39 with 20'h00030.
- Clear priority and reset: reset_button and done_tick in the same cycle → acc=0, tick ignored, bcd→0 after conversion. rst asserted at T+10 mid-conversion → no bcd_valid, all outputs 0.
